// File: rtl/element_serializer.sv
// Serializes one {row, col, value} element per handshake into an MSB-first dibit burst on axiov/axiod.
// Optional macro ELEMENT_SERIALIZER_PREAMBLE_EN prefixes every burst with dibits 01,01,01,11.
module element_serializer #(
  parameter int MAX_ELEMENT_SIZE = 8,
  parameter int MAX_ROW_SIZE_A   = 32,
  parameter int MAX_COL_SIZE_A   = 32,
  parameter int WORD_WIDTH       = 32,
  parameter int GAP_CYCLES       = 2,
  localparam int ROW_W     = $clog2(MAX_ROW_SIZE_A),
  localparam int COL_W     = $clog2(MAX_COL_SIZE_A),
  localparam int PAYLOAD_W = MAX_ELEMENT_SIZE + ROW_W + COL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 axiiv,
  input  logic [PAYLOAD_W-1:0] axiid,
  output logic                 axiir,
  output logic                 axiov,
  output logic [1:0]           axiod,
  output logic                 busy
);

`ifdef ELEMENT_SERIALIZER_PREAMBLE_EN
  localparam int PRE_W = 8;
`else
  localparam int PRE_W = 0;
`endif
  localparam int SHIFT_W = WORD_WIDTH + PRE_W;
  localparam int NDIB    = SHIFT_W / 2;
  localparam int CNT_W   = $clog2(NDIB);
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_DIB = CNT_W'(NDIB - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                 state_q, state_d;
  logic [PAYLOAD_W-1:0]   hold_q, hold_d;
  logic                   hold_valid_q, hold_valid_d;
  logic [SHIFT_W-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0]       dcnt_q, dcnt_d;
  logic [GAP_W-1:0]       gcnt_q, gcnt_d;
  logic                   axiov_q, axiov_d;
  logic [1:0]             axiod_q, axiod_d;

  logic [WORD_WIDTH-1:0]  word;
  logic [SHIFT_W-1:0]     load_word;

  assign word = WORD_WIDTH'(hold_q);
`ifdef ELEMENT_SERIALIZER_PREAMBLE_EN
  assign load_word = {8'b01_01_01_11, word};
`else
  assign load_word = word;
`endif

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    shift_d      = shift_q;
    dcnt_d       = dcnt_q;
    gcnt_d       = gcnt_q;
    axiov_d      = axiov_q;
    axiod_d      = axiod_q;

    // Accept and drain never coincide: accept needs the hold empty, drain needs it full.
    if (axiiv && !hold_valid_q) begin
      hold_d       = axiid;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hold_valid_q) begin
          hold_valid_d = 1'b0;
          state_d      = SEND;
          axiov_d      = 1'b1;
          axiod_d      = load_word[SHIFT_W-1 -: 2];
          shift_d      = load_word << 2;
          dcnt_d       = '0;
        end
      end
      SEND: begin
        if (dcnt_q == LAST_DIB) begin
          state_d = GAP;
          axiov_d = 1'b0;
          axiod_d = 2'b00;
          gcnt_d  = GAP_LAST;
        end else begin
          dcnt_d  = dcnt_q + 1'b1;
          axiod_d = shift_q[SHIFT_W-1 -: 2];
          shift_d = shift_q << 2;
        end
      end
      GAP: begin
        if (gcnt_q == '0) state_d = IDLE;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      shift_q      <= '0;
      dcnt_q       <= '0;
      gcnt_q       <= '0;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      shift_q      <= shift_d;
      dcnt_q       <= dcnt_d;
      gcnt_q       <= gcnt_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
    end
  end

  assign axiov = axiov_q;
  assign axiod = axiod_q;
  assign busy  = (state_q != IDLE) | hold_valid_q;
  assign axiir = rst_n & ~hold_valid_q;

endmodule

// File: tb/tb_element_serializer.sv
// Directed bench for element_serializer: reset, single element, back-to-back, backpressure,
// mid-burst reset and a 32-element loopback through a behavioural dibit receiver.
module tb_element_serializer;
  localparam int PW = 18;
`ifdef ELEMENT_SERIALIZER_PREAMBLE_EN
  localparam int NDIB = 20;
`else
  localparam int NDIB = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          axiiv;
  logic [PW-1:0] axiid;
  logic          axiir;
  logic          axiov;
  logic [1:0]    axiod;
  logic          busy;

  int total = 0;
  int passed = 0;

  // receiver state, written only by the monitor process
  logic [63:0] rx_q[$];
  int          len_q[$];
  int          gap_q[$];
  int          rise_cnt = 0;
  int          idle_err = 0;

  always #5 clk = ~clk;

  element_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiir (axiir),
    .axiov (axiov),
    .axiod (axiod),
    .busy  (busy)
  );

  initial begin : monitor
    logic [63:0] cur;
    int          cur_len;
    int          low_run;
    bit          prev_v;
    bit          seen;
    cur = '0; cur_len = 0; low_run = 0; prev_v = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (axiov && !prev_v) begin
        rise_cnt++;
        if (seen) gap_q.push_back(low_run);
        cur = '0;
        cur_len = 0;
      end
      if (axiov) begin
        cur = {cur[61:0], axiod};
        cur_len++;
        low_run = 0;
      end else begin
        low_run++;
        if (axiod !== 2'b00) idle_err++;
        if (prev_v) begin
          rx_q.push_back(cur);
          len_q.push_back(cur_len);
          seen = 1;
        end
      end
      prev_v = axiov;
    end
  end

  function automatic logic [63:0] build_exp(input logic [31:0] w);
`ifdef ELEMENT_SERIALIZER_PREAMBLE_EN
    return {24'd0, 8'b01010111, w};
`else
    return {32'd0, w};
`endif
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [PW-1:0] d, output bit ok);
    ok = 0;
    axiid = d;
    axiiv = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (axiir) ok = 1;
      step();
    end
    axiiv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; axiiv = 1'b0; axiid = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (axiov !== 1'b0) $display("FAIL reset_axiov got=%b exp=0", axiov); else passed++;
    total++; if (axiod !== 2'b00) $display("FAIL reset_axiod got=%b exp=00", axiod); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (axiir !== 1'b0) $display("FAIL reset_axiir got=%b exp=0", axiir); else passed++;
    #2 rst_n = 1'b1;
    step();
    total++; if (axiir !== 1'b1) $display("FAIL post_reset_axiir got=%b exp=1", axiir); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL post_reset_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_single();
    logic [63:0] e;
    logic [1:0]  exp_d;
    bit          ok;
    e = build_exp(32'h000065A5);
    send({5'd3, 5'd5, 8'hA5}, ok);
    total++; if (!ok) $display("FAIL single_accept got=0 exp=1"); else passed++;
    total++; if (axiov !== 1'b0 || busy !== 1'b1 || axiir !== 1'b0)
      $display("FAIL single_hold got=v%b b%b r%b exp=v0 b1 r0", axiov, busy, axiir); else passed++;
    step();
    for (int i = 0; i < NDIB; i++) begin
      exp_d = e[2*NDIB-1-2*i -: 2];
      total++;
      if (axiov !== 1'b1 || axiod !== exp_d)
        $display("FAIL single_dibit%0d got=v%b d%b exp=v1 d%b", i, axiov, axiod, exp_d);
      else passed++;
      step();
    end
    total++; if (axiov !== 1'b0 || axiod !== 2'b00 || busy !== 1'b1)
      $display("FAIL single_end got=v%b d%b b%b exp=v0 d00 b1", axiov, axiod, busy); else passed++;
    step(); step();
    total++; if (busy !== 1'b0 || axiir !== 1'b1 || axiov !== 1'b0)
      $display("FAIL single_idle got=b%b r%b v%b exp=b0 r1 v0", busy, axiir, axiov); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] el[3];
    logic [31:0]   ew[3];
    int            base, k, g;
    bit            r;
    el[0] = 18'h00001; el[1] = 18'h00002; el[2] = 18'h000FF;
    ew[0] = 32'h00000001; ew[1] = 32'h00000002; ew[2] = 32'h000000FF;
    base = rx_q.size();
    k = 0;
    axiid = el[0];
    axiiv = 1'b1;
    for (int n = 0; n < 300 && k < 3; n++) begin
      r = axiir;
      step();
      if (r) begin
        k++;
        total++; if (axiir !== 1'b0) $display("FAIL b2b_ready_full%0d got=%b exp=0", k, axiir); else passed++;
        if (k < 3) axiid = el[k];
      end
    end
    axiiv = 1'b0;
    total++; if (k != 3) $display("FAIL b2b_accepts got=%0d exp=3", k); else passed++;
    for (int n = 0; n < 300 && rx_q.size() < base + 3; n++) step();
    total++; if (rx_q.size() < base + 3) $display("FAIL b2b_bursts got=%0d exp=3", rx_q.size() - base);
    else begin
      passed++;
      for (int i = 0; i < 3; i++) begin
        total++;
        if (rx_q[base+i] !== build_exp(ew[i]) || len_q[base+i] != NDIB)
          $display("FAIL b2b_word%0d got=%h len=%0d exp=%h len=%0d", i, rx_q[base+i], len_q[base+i],
                   build_exp(ew[i]), NDIB);
        else passed++;
      end
      for (int i = 1; i <= 2; i++) begin
        g = gap_q[gap_q.size()-i];
        total++; if (g < 3) $display("FAIL b2b_gap%0d got=%0d exp>=3", i, g); else passed++;
      end
    end
    repeat (4) step();
  endtask

  task automatic test_backpressure();
    int            base, acc, seq;
    bit            r, ok;
    logic [PW-1:0] a;
    a = {5'd1, 5'd2, 8'h10};
    base = rx_q.size();
    send(a, ok);
    for (int n = 0; n < 10 && !axiov; n++) step();
    total++; if (axiov !== 1'b1) $display("FAIL bp_start got=%b exp=1", axiov); else passed++;
    seq = 1; acc = 0;
    axiid = {5'd7, 5'd9, 8'(seq)};
    axiiv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r = axiir;
      step();
      if (r) begin acc++; seq++; axiid = {5'd7, 5'd9, 8'(seq)}; end
    end
    total++; if (acc != 1 || axiir !== 1'b0)
      $display("FAIL bp_one_extra got=acc%0d r%b exp=acc1 r0", acc, axiir); else passed++;
    for (int n = 0; n < 300 && seq < 4; n++) begin
      r = axiir;
      step();
      if (r) begin seq++; axiid = {5'd7, 5'd9, 8'(seq)}; end
    end
    axiiv = 1'b0;
    for (int n = 0; n < 300 && rx_q.size() < base + 4; n++) step();
    total++; if (rx_q.size() < base + 4) $display("FAIL bp_bursts got=%0d exp=4", rx_q.size() - base);
    else begin
      passed++;
      total++; if (rx_q[base] !== build_exp(32'(a)))
        $display("FAIL bp_word0 got=%h exp=%h", rx_q[base], build_exp(32'(a))); else passed++;
      for (int i = 1; i < 4; i++) begin
        total++;
        if (rx_q[base+i] !== build_exp(32'({5'd7, 5'd9, 8'(i)})))
          $display("FAIL bp_seq%0d got=%h exp=%h", i, rx_q[base+i], build_exp(32'({5'd7, 5'd9, 8'(i)})));
        else passed++;
      end
    end
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rb;
    send({5'd3, 5'd5, 8'hA5}, ok);
    for (int n = 0; n < 10 && !axiov; n++) step();
    axiid = {5'd4, 5'd4, 8'h3C};
    axiiv = 1'b1;
    step();
    axiiv = 1'b0;
    repeat (6) step();
    total++; if (busy !== 1'b1 || axiov !== 1'b1)
      $display("FAIL mid_before got=b%b v%b exp=b1 v1", busy, axiov); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (axiov !== 1'b0 || axiod !== 2'b00)
      $display("FAIL mid_async_out got=v%b d%b exp=v0 d00", axiov, axiod); else passed++;
    total++; if (busy !== 1'b0 || axiir !== 1'b0)
      $display("FAIL mid_async_ctl got=b%b r%b exp=b0 r0", busy, axiir); else passed++;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    total++; if (axiir !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_release got=r%b b%b exp=r1 b0", axiir, busy); else passed++;
    rb = rise_cnt;
    repeat (40) step();
    total++; if (rise_cnt != rb || axiov !== 1'b0)
      $display("FAIL mid_no_burst got=%0d exp=0", rise_cnt - rb); else passed++;
  endtask

  task automatic test_loopback();
    logic [PW-1:0] d[32];
    int            base;
    bit            ok;
    base = rx_q.size();
    for (int i = 0; i < 32; i++) begin
      d[i] = PW'($urandom_range(0, 262143));
      send(d[i], ok);
      if (!ok) begin
        total++;
        $display("FAIL loop_accept%0d got=timeout exp=accept", i);
      end
    end
    for (int n = 0; n < 2000 && rx_q.size() < base + 32; n++) step();
    total++; if (rx_q.size() < base + 32) $display("FAIL loop_count got=%0d exp=32", rx_q.size() - base);
    else begin
      passed++;
      for (int i = 0; i < 32; i++) begin
        total++;
        if (rx_q[base+i] !== build_exp(32'(d[i])) || len_q[base+i] != NDIB)
          $display("FAIL loop_word%0d got=%h len=%0d exp=%h", i, rx_q[base+i], len_q[base+i],
                   build_exp(32'(d[i])));
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_loopback();
    repeat (5) step();
    total++; if (idle_err != 0) $display("FAIL idle_axiod got=%0d exp=0", idle_err); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
